// File: rtl/merge_fifo_pkg.sv
// Common types and defaults for merge_fifo; statistics gated by MERGE_FIFO_STATS_EN.
`include "merge_fifo_defs.vh"
package merge_fifo_pkg;
   localparam int DEF_WIDTH = `MERGE_FIFO_WIDTH;
   localparam int DEF_DEPTH = `MERGE_FIFO_DEPTH;
   localparam int DEF_SLACK = `MERGE_FIFO_SLACK;
   localparam int STATS_W   = `MERGE_FIFO_STATS_W;

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_PUSH = 2'd1,
      OP_POP  = 2'd2,
      OP_BOTH = 2'd3
   } fifo_op_e;

   function automatic fifo_op_e fifo_op(input logic push, input logic pop);
      return fifo_op_e'({pop, push});
   endfunction
endpackage

// File: rtl/merge_fifo_defs.vh
// Shared defaults for the merge stage and its downstream elastic buffer.
// Optional statistics outputs are enabled by defining MERGE_FIFO_STATS_EN.
`ifndef MERGE_FIFO_DEFS_VH
`define MERGE_FIFO_DEFS_VH
`define MERGE_FIFO_WIDTH   40
`define MERGE_FIFO_DEPTH   8
`define MERGE_FIFO_SLACK   2
`define MERGE_FIFO_AW(d)   $clog2(d)
`define MERGE_FIFO_STATS_W 32
`endif

// File: rtl/merge_fifo_mem.sv
// DEPTH x WIDTH storage for merge_fifo: one synchronous write port, one asynchronous read port.
module merge_fifo_mem
   import merge_fifo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   localparam int AW   = `MERGE_FIFO_AW(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem_q [DEPTH];

   // Storage write; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];
endmodule

// File: rtl/merge_fifo.sv
// Elastic FWFT buffer behind the 3:1 merger; pause_up keeps SLACK slots for in-flight beats.
// Define MERGE_FIFO_STATS_EN to add the hwm / beats statistics outputs.
`include "merge_fifo_defs.vh"
module merge_fifo
   import merge_fifo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int SLACK = DEF_SLACK,
   localparam int AW   = `MERGE_FIFO_AW(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             vdin,
   input  logic [WIDTH-1:0] din,
   output logic             pause_up,
   output logic             vdout,
   output logic [WIDTH-1:0] dout,
   input  logic             pause_dn,
   output logic             ovf,
`ifdef MERGE_FIFO_STATS_EN
   output logic [AW:0]      hwm,
   output logic [STATS_W-1:0] beats,
`endif
   output logic [AW:0]      count
);
   localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
   localparam logic [AW:0]   THRESH_C = (AW+1)'(DEPTH - SLACK);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

   logic            push_s, pop_s, drop_s;
   logic [AW-1:0]   wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
   logic [AW:0]     count_d, count_q;
   logic            vdout_d, vdout_q, pause_up_d, pause_up_q, ovf_d, ovf_q;

   // Handshake decode and next-state for pointers, occupancy and flags.
   always_comb begin
      pop_s    = vdout_q & ~pause_dn;
      push_s   = vdin & ((count_q < DEPTH_C) | pop_s);
      drop_s   = vdin & ~push_s;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      case (fifo_op(push_s, pop_s))
         OP_PUSH: begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            count_d  = count_q + CNT_ONE;
         end
         OP_POP: begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            count_d  = count_q - CNT_ONE;
         end
         OP_BOTH: begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         default: begin
            count_d = count_q;
         end
      endcase
      // Flags are registered from next occupancy, so they equal a decode of count_q.
      vdout_d    = (count_d != '0);
      pause_up_d = (count_d >= THRESH_C);
      ovf_d      = ovf_q | drop_s;
   end

   // Control state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         vdout_q    <= 1'b0;
         pause_up_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         vdout_q    <= vdout_d;
         pause_up_q <= pause_up_d;
         ovf_q      <= ovf_d;
      end
   end

   merge_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
      .clk   (clk),
      .we    (push_s),
      .waddr (wr_ptr_q),
      .wdata (din),
      .raddr (rd_ptr_q),
      .rdata (dout)
   );

   assign count    = count_q;
   assign vdout    = vdout_q;
   assign pause_up = pause_up_q;
   assign ovf      = ovf_q;

`ifdef MERGE_FIFO_STATS_EN
   logic [AW:0]        hwm_d, hwm_q;
   logic [STATS_W-1:0] beats_d, beats_q;

   // High-water mark and accepted-beat counter next state.
   always_comb begin
      if (count_d > hwm_q) begin
         hwm_d = count_d;
      end else begin
         hwm_d = hwm_q;
      end
      beats_d = beats_q + STATS_W'(push_s);
   end

   // Statistics registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hwm_q   <= '0;
         beats_q <= '0;
      end else begin
         hwm_q   <= hwm_d;
         beats_q <= beats_d;
      end
   end

   assign hwm   = hwm_q;
   assign beats = beats_q;
`endif
endmodule

// File: tb/tb_merge_fifo.sv
// Randomized self-checking bench for merge_fifo against a queue-based reference model.
`timescale 1ns/1ps
module tb_merge_fifo;
   localparam int W = 40;
   localparam int D = 8;
   localparam int S = 2;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         vdin = 1'b0;
   logic [W-1:0] din = '0;
   logic         pause_dn = 1'b1;
   logic         pause_up, vdout, ovf;
   logic [W-1:0] dout;
   logic [3:0]   count;
`ifdef MERGE_FIFO_STATS_EN
   logic [3:0]   hwm;
   logic [31:0]  beats;
`endif

   merge_fifo dut (
      .clk      (clk),
      .reset    (reset),
      .vdin     (vdin),
      .din      (din),
      .pause_up (pause_up),
      .vdout    (vdout),
      .dout     (dout),
      .pause_dn (pause_dn),
      .ovf      (ovf),
`ifdef MERGE_FIFO_STATS_EN
      .hwm      (hwm),
      .beats    (beats),
`endif
      .count    (count)
   );

   always #5 clk = ~clk;

   // Reference model: plain queue of held beats plus sticky flag and statistics.
   logic [W-1:0] mq [$];
   bit           m_ovf = 1'b0;
   int           m_hwm = 0;
   int           m_beats = 0;
   bit           last_pop;
   logic [W-1:0] last_pop_val;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, "_count"}, 64'(count), 64'(mq.size()));
      check({tag, "_vdout"}, 64'(vdout), 64'(mq.size() != 0));
      check({tag, "_pause_up"}, 64'(pause_up), 64'(mq.size() >= D - S));
      check({tag, "_ovf"}, 64'(ovf), 64'(m_ovf));
      if (mq.size() != 0) check({tag, "_dout"}, 64'(dout), 64'(mq[0]));
`ifdef MERGE_FIFO_STATS_EN
      check({tag, "_hwm"}, 64'(hwm), 64'(m_hwm));
      check({tag, "_beats"}, 64'(beats), 64'(m_beats));
`endif
   endtask

   // Called just after a falling edge: drive, advance one rising edge, compare at next falling edge.
   task automatic step(input string tag, input logic v, input logic [W-1:0] d, input logic pd);
      bit do_pop, do_push;
      vdin = v;
      din = d;
      pause_dn = pd;
      do_pop  = (mq.size() != 0) && !pd;
      do_push = v && ((mq.size() < D) || do_pop);
      @(posedge clk);
      last_pop = do_pop;
      if (do_pop) last_pop_val = mq.pop_front();
      if (do_push) begin
         mq.push_back(d);
         m_beats++;
      end
      if (v && !do_push) m_ovf = 1'b1;
      if (mq.size() > m_hwm) m_hwm = mq.size();
      @(negedge clk);
      compare_all(tag);
   endtask

   task automatic model_reset();
      mq.delete();
      m_ovf = 1'b0;
      m_hwm = 0;
      m_beats = 0;
   endtask

   // Assert reset between edges and check the outputs fall before the next rising edge.
   task automatic async_reset(input string tag);
      vdin = 1'b0;
      pause_dn = 1'b1;
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      compare_all(tag);
      check({tag, "_pause_up_low"}, 64'(pause_up), 64'(0));
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int next_in, exp_out, slack_used, cycles;
      bit want;
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      compare_all("reset");

      // Scenario 1: fill with 1..8 under consumer stall.
      for (int i = 1; i <= 8; i++) begin
         step("s1", 1'b1, W'(i), 1'b1);
         if (i == 5) check("s1_pause_after5", 64'(pause_up), 64'(0));
         if (i == 6) check("s1_pause_after6", 64'(pause_up), 64'(1));
      end
      check("s1_full", 64'(count), 64'(8));
      check("s1_no_ovf", 64'(ovf), 64'(0));

      // Scenario 2: 9th beat is dropped, ovf sticks.
      step("s2", 1'b1, W'(9), 1'b1);
      check("s2_ovf", 64'(ovf), 64'(1));
      check("s2_count", 64'(count), 64'(8));
      step("s2_hold", 1'b0, W'(0), 1'b1);
      check("s2_ovf_sticky", 64'(ovf), 64'(1));

      // Scenario 3: full with simultaneous push and pop.
      step("s3", 1'b1, W'(10), 1'b0);
      check("s3_popped", 64'(last_pop_val), 64'(1));
      check("s3_count", 64'(count), 64'(8));
      check("s3_head", 64'(dout), 64'(2));
      check("s3_ovf", 64'(ovf), 64'(1));

      // Async reset while full with ovf set.
      async_reset("s6_full");

      // Scenario 4: single beat latency through an empty FIFO.
      step("s4_push", 1'b1, W'(8'h55), 1'b0);
      check("s4_vdout", 64'(vdout), 64'(1));
      check("s4_dout", 64'(dout), 64'(8'h55));
      step("s4_pop", 1'b0, W'(0), 1'b0);
      check("s4_popped", 64'(last_pop), 64'(1));
      check("s4_empty", 64'(vdout), 64'(0));

      // Scenario 5: random traffic from a merger honouring pause_up with 2-beat slack.
      next_in = 0;
      exp_out = 0;
      slack_used = 0;
      cycles = 0;
      while (exp_out < 100 && cycles < 4000) begin
         if (!pause_up) slack_used = 0;
         want = (next_in < 100) && ($urandom_range(0, 99) < 70) &&
                (!pause_up || slack_used < S);
         if (want && pause_up) slack_used++;
         step("s5", want, W'(next_in), ($urandom_range(0, 2) == 0));
         if (want) next_in++;
         if (last_pop) begin
            check("s5_order", 64'(last_pop_val), 64'(exp_out));
            exp_out++;
         end
         cycles++;
      end
      check("s5_all_out", 64'(exp_out), 64'(100));
      check("s5_no_ovf", 64'(ovf), 64'(0));

      // Scenario 6: count=5 then asynchronous reset.
      for (int i = 0; i < 5; i++) step("s6_fill", 1'b1, W'(i + 200), 1'b1);
      check("s6_count5", 64'(count), 64'(5));
      async_reset("s6");
      compare_all("s6_after");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
